ifft_seq: RTL and testbench
===========================

IFFT_SEQ -- requirements
Module: ifft_seq

Interface
REQ-001 SHALL have parameter N, default 4: number of complex samples per frame; power of 2, N >= 2.
REQ-002 SHALL have parameter WIDTH, default 12: signed two's-complement width of each real/imag component.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  input sample valid.
REQ-006 SHALL have port in_ready  output  1  block accepts an input sample.
REQ-007 SHALL have ports in_re, in_im  input  WIDTH each  signed frequency-domain sample X[k], k in natural order 0..N-1.
REQ-008 SHALL have port out_valid  output  1  output sample valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the output sample.
REQ-010 SHALL have ports out_re, out_im  output  WIDTH each  signed time-domain sample x[n], n in natural order 0..N-1.
REQ-011 SHALL have port out_last  output  1  high with out_valid on sample n = N-1.
REQ-012 SHALL have port busy  output  1  high in COMPUTE or UNLOAD.

Function
REQ-013 SHALL compute x[n] = (1/N)·sum_k X[k]·exp(+j2πkn/N) as an iterative radix-2 decimation-in-time inverse transform using one butterfly per cycle and a single N-entry complex buffer.
REQ-014 SHALL implement FSM states LOAD, COMPUTE, UNLOAD; LOAD -> COMPUTE on the Nth input handshake; COMPUTE -> UNLOAD after the last butterfly; UNLOAD -> LOAD on the Nth output handshake.
REQ-015 SHALL assert in_ready only in LOAD; a handshake (in_valid & in_ready) writes sample k to buffer address bitreverse(k); in_valid low leaves the counter unchanged.
REQ-016 SHALL spend exactly log2(N)·N/2 cycles in COMPUTE (stage s = 1..log2 N, span m = 2^s, N/2 butterflies per stage, stage s+1 starting only after stage s completes).
REQ-017 SHALL use twiddle W = (round(cos(2πj/m)·2^F), round(sin(2πj/m)·2^F)), F = WIDTH-2, where j is the index within the half-group.
REQ-018 SHALL form t_re = (b_re·w_re - b_im·w_im) >>> F and t_im = (b_re·w_im + b_im·w_re) >>> F from full-precision products; then a' = (a+t) >>> 1, b' = (a-t) >>> 1 with sums in WIDTH+2 bits, truncated to WIDTH (>>> is arithmetic shift, rounding toward -inf).
REQ-019 SHALL present the first out_valid exactly log2(N)·N/2 + 1 cycles after the Nth input handshake.
REQ-020 SHALL hold out_re/out_im/out_last stable while out_valid & !out_ready; the index advances only on a handshake.
REQ-021 SHALL keep out_valid low outside UNLOAD, and drive out_re/out_im to 0 when out_valid is low.
REQ-022 SHALL accept no input during COMPUTE/UNLOAD (in_ready = 0); the upstream holds its data.
REQ-023 SHALL return to LOAD with in_ready = 1 in the cycle after the final output handshake, so back-to-back frames lose no cycle beyond the handshakes.

Reset
REQ-024 SHALL, on rst high at any time, asynchronously force state = LOAD, all counters = 0, out_valid = 0, out_last = 0, out_re = out_im = 0, busy = 0, and in_ready = 1 once rst is released.
REQ-025 SHALL discard any partially loaded, computed or unloaded frame on reset; buffer contents need not be cleared.
REQ-026 SHALL accept a new frame starting in the first clock edge after rst deasserts.

Verification
REQ-027 Impulse (N=4, WIDTH=12): X = {(1024,0),(0,0),(0,0),(0,0)} -> x = {(256,0),(256,0),(256,0),(256,0)}, out_last on the 4th, first out_valid 5 cycles after the last input.
REQ-028 Constant: X[k] = (1024,0) for all k -> x = {(1024,0),(0,0),(0,0),(0,0)}.
REQ-029 Single bin: X[1] = (1024,0), others 0 -> x = {(256,0),(0,256),(-256,0),(0,-256)}.
REQ-030 Floor rounding: X[0] = (-1,0), others 0 -> x = {(-1,0),(-1,0),(-1,0),(-1,0)}.
REQ-031 Backpressure: out_ready low for 3 cycles after the 2nd output -> sample 2 held stable, all 4 samples delivered once, in order, out_last only on the 4th.
REQ-032 Reset during COMPUTE: rst pulse -> out_valid = 0, busy = 0 immediately; then a fresh impulse frame yields four (256,0) outputs.

Source files
------------

// File: rtl/ifft_seq.sv
// Iterative radix-2 DIT inverse FFT: loads N samples in bit-reversed order, runs one
// butterfly per cycle in place on a single N-entry buffer, then streams x[n] out.
module ifft_seq #(
  parameter int N     = 4,
  parameter int WIDTH = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_re,
  input  logic signed [WIDTH-1:0] in_im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_re,
  output logic signed [WIDTH-1:0] out_im,
  output logic                    out_last,
  output logic                    busy
);

  localparam int  LOGN = $clog2(N);
  localparam int  F    = WIDTH - 2;
  localparam int  PW   = 2 * WIDTH + 1;
  localparam int  SW   = WIDTH + 2;
  localparam real PI   = 3.14159265358979323846;

  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

  state_t                  state_q, state_d;
  logic [LOGN-1:0]         cnt_q, cnt_d;
  logic [LOGN-1:0]         stage_q, stage_d;
  logic [LOGN-1:0]         bfly_q, bfly_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic signed [WIDTH-1:0] out_re_q, out_re_d;
  logic signed [WIDTH-1:0] out_im_q, out_im_d;
  logic signed [WIDTH-1:0] mem_re_q [N];
  logic signed [WIDTH-1:0] mem_im_q [N];
  logic signed [WIDTH-1:0] mem_re_d [N];
  logic signed [WIDTH-1:0] mem_im_d [N];

  // Twiddle table exp(+j2*pi*i/N) in Q(F); stage span m uses index j*(N/m).
  logic signed [WIDTH-1:0] tw_re [N];
  logic signed [WIDTH-1:0] tw_im [N];

  for (genvar i = 0; i < N; i++) begin : g_tw
    localparam real CR = $cos(2.0 * PI * i / N) * real'(1 << F);
    localparam real SR = $sin(2.0 * PI * i / N) * real'(1 << F);
    localparam int  CI = $rtoi(CR >= 0.0 ? CR + 0.5 : CR - 0.5);
    localparam int  SI = $rtoi(SR >= 0.0 ? SR + 0.5 : SR - 0.5);
    assign tw_re[i] = WIDTH'(CI);
    assign tw_im[i] = WIDTH'(SI);
  end

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
    logic [LOGN-1:0] r;
    r = '0;
    for (int i = 0; i < LOGN; i++) r[i] = v[LOGN-1-i];
    return r;
  endfunction

  logic [LOGN-1:0]         half, top, bot, tw_idx, nxt;
  logic signed [WIDTH-1:0] a_re, a_im, b_re, b_im, w_re, w_im;
  logic signed [PW-1:0]    p_re, p_im;
  logic signed [SW-1:0]    t_re, t_im, sum_re, sum_im, dif_re, dif_im;
  logic signed [WIDTH-1:0] na_re, na_im, nb_re, nb_im;

  always_comb begin
    half   = LOGN'(1) << stage_q;
    top    = (((bfly_q >> stage_q) << stage_q) << 1) | (bfly_q & (half - LOGN'(1)));
    bot    = top | half;
    tw_idx = (bfly_q & (half - LOGN'(1))) << (LOGN'(LOGN - 1) - stage_q);
    a_re   = mem_re_q[top];
    a_im   = mem_im_q[top];
    b_re   = mem_re_q[bot];
    b_im   = mem_im_q[bot];
    w_re   = tw_re[tw_idx];
    w_im   = tw_im[tw_idx];
    p_re   = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im);
    p_im   = PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re);
    t_re   = SW'(p_re >>> F);
    t_im   = SW'(p_im >>> F);
    sum_re = SW'(a_re) + t_re;
    sum_im = SW'(a_im) + t_im;
    dif_re = SW'(a_re) - t_re;
    dif_im = SW'(a_im) - t_im;
    na_re  = WIDTH'(sum_re >>> 1);
    na_im  = WIDTH'(sum_im >>> 1);
    nb_re  = WIDTH'(dif_re >>> 1);
    nb_im  = WIDTH'(dif_im >>> 1);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stage_d     = stage_q;
    bfly_d      = bfly_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    mem_re_d    = mem_re_q;
    mem_im_d    = mem_im_q;
    nxt         = cnt_q + LOGN'(1);
    case (state_q)
      LOAD: begin
        if (in_valid) begin
          mem_re_d[bitrev(cnt_q)] = in_re;
          mem_im_d[bitrev(cnt_q)] = in_im;
          if (cnt_q == LOGN'(N - 1)) begin
            state_d = COMPUTE;
            cnt_d   = '0;
          end else begin
            cnt_d = nxt;
          end
        end
      end
      COMPUTE: begin
        mem_re_d[top] = na_re;
        mem_im_d[top] = na_im;
        mem_re_d[bot] = nb_re;
        mem_im_d[bot] = nb_im;
        if (bfly_q == LOGN'(N / 2 - 1)) begin
          bfly_d = '0;
          if (stage_q == LOGN'(LOGN - 1)) begin
            state_d = UNLOAD;
            stage_d = '0;
          end else begin
            stage_d = stage_q + LOGN'(1);
          end
        end else begin
          bfly_d = bfly_q + LOGN'(1);
        end
      end
      UNLOAD: begin
        // First UNLOAD cycle only primes the output register with x[0].
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_re_d    = mem_re_q[cnt_q];
          out_im_d    = mem_im_q[cnt_q];
          out_last_d  = (cnt_q == LOGN'(N - 1));
        end else if (out_ready) begin
          if (out_last_q) begin
            state_d     = LOAD;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_re_d    = '0;
            out_im_d    = '0;
          end else begin
            cnt_d      = nxt;
            out_re_d   = mem_re_q[nxt];
            out_im_d   = mem_im_q[nxt];
            out_last_d = (nxt == LOGN'(N - 1));
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      stage_q     <= '0;
      bfly_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stage_q     <= stage_d;
      bfly_q      <= bfly_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
    end
  end

  // Sample buffer is never reset; a new frame overwrites every entry.
  always_ff @(posedge clk) begin
    mem_re_q <= mem_re_d;
    mem_im_q <= mem_im_d;
  end

  assign in_ready  = (state_q == LOAD);
  assign busy      = (state_q != LOAD);
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;

endmodule

// File: tb/tb_ifft_seq.sv
// Directed bench for ifft_seq (N=4, WIDTH=12) with hand-computed expected frames.
module tb_ifft_seq;

  localparam int W = 12;

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_re;
  logic signed [W-1:0] in_im;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_re;
  logic signed [W-1:0] out_im;
  logic                out_last;
  logic                busy;

  int vec_count = 0;
  int miscompares = 0;

  int fr_re [4];
  int fr_im [4];
  int got_re [4];
  int got_im [4];
  bit got_last [4];
  int n_got;
  int lat;
  bit ready_seen;
  bit busy_low_seen;
  bit post_ready;
  bit post_valid;
  int hold_re [3];
  int hold_im [3];
  bit hold_valid [3];
  bit hold_last [3];

  ifft_seq #(.N(4), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_last  (out_last),
    .busy      (busy)
  );

  // 10 ns clock; inputs change and outputs are sampled around the falling edge
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so a stuck design can never hang the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Drive the frame in fr_re/fr_im; optional idle cycle before sample gap_at
  task automatic load_frame(input int gap_at, input bit immediate);
    for (int k = 0; k < 4; k++) begin
      if (!(immediate && k == 0)) @(negedge clk);
      if (k == gap_at) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_re    = 12'(fr_re[k]);
      in_im    = 12'(fr_im[k]);
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    in_re    = '0;
    in_im    = '0;
  endtask

  // Wait for the output burst, record latency and samples, optionally stalling out_ready
  task automatic collect(input int stall_at, input int stall_len);
    int guard;
    out_ready     = 1'b1;
    n_got         = 0;
    lat           = 0;
    ready_seen    = 1'b0;
    busy_low_seen = 1'b0;
    @(negedge clk);
    while (!out_valid && lat < 50) begin
      if (in_ready) ready_seen = 1'b1;
      if (!busy) busy_low_seen = 1'b1;
      lat++;
      @(negedge clk);
    end
    guard = 0;
    while (n_got < 4 && guard < 100) begin
      if (out_valid) begin
        if (n_got == stall_at) begin
          out_ready = 1'b0;
          for (int c = 0; c < stall_len; c++) begin
            @(negedge clk);
            hold_re[c]    = int'(out_re);
            hold_im[c]    = int'(out_im);
            hold_valid[c] = out_valid;
            hold_last[c]  = out_last;
          end
          out_ready = 1'b1;
        end
        got_re[n_got]   = int'(out_re);
        got_im[n_got]   = int'(out_im);
        got_last[n_got] = out_last;
        n_got++;
      end
      @(negedge clk);
      guard++;
    end
    post_ready = in_ready;
    post_valid = out_valid;
  endtask

  // Reset state while rst is held, then release just after a rising edge
  task automatic test_reset();
    repeat (2) @(negedge clk);
    vec_count++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: valid=%0b busy=%0b last=%0b required 0 0 0", out_valid, busy, out_last);
    end
    vec_count++;
    if (out_re !== 12'sd0 || out_im !== 12'sd0) begin
      miscompares++;
      $display("[TB] FAIL reset_data: got (%0d,%0d) required (0,0)", out_re, out_im);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    vec_count++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_in_ready: got %0b required 1", in_ready);
    end
  endtask

  // Impulse with an idle input cycle mid-frame; starts right after reset release
  task automatic test_impulse();
    int er [4] = '{256, 256, 256, 256};
    int ei [4] = '{0, 0, 0, 0};
    fr_re = '{1024, 0, 0, 0};
    fr_im = '{0, 0, 0, 0};
    load_frame(2, 1'b0);
    collect(-1, 0);
    vec_count++;
    if (lat !== 5) begin
      miscompares++;
      $display("[TB] FAIL impulse_latency: got %0d cycles required 5", lat);
    end
    vec_count++;
    if (ready_seen || busy_low_seen) begin
      miscompares++;
      $display("[TB] FAIL impulse_compute_flags: in_ready_seen=%0b busy_low_seen=%0b required 0 0", ready_seen, busy_low_seen);
    end
    vec_count++;
    if (n_got !== 4) begin
      miscompares++;
      $display("[TB] FAIL impulse_count: got %0d samples required 4", n_got);
    end
    for (int i = 0; i < 4; i++) begin
      vec_count++;
      if (got_re[i] !== er[i] || got_im[i] !== ei[i]) begin
        miscompares++;
        $display("[TB] FAIL impulse_x[%0d]: got (%0d,%0d) required (%0d,%0d)", i, got_re[i], got_im[i], er[i], ei[i]);
      end
      vec_count++;
      if (got_last[i] !== (i == 3)) begin
        miscompares++;
        $display("[TB] FAIL impulse_last[%0d]: got %0b required %0b", i, got_last[i], (i == 3));
      end
    end
    vec_count++;
    if (post_ready !== 1'b1 || post_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL impulse_return: in_ready=%0b out_valid=%0b required 1 0", post_ready, post_valid);
    end
  endtask

  // Constant spectrum collapses to a single time-domain sample
  task automatic test_constant();
    int er [4] = '{1024, 0, 0, 0};
    int ei [4] = '{0, 0, 0, 0};
    fr_re = '{1024, 1024, 1024, 1024};
    fr_im = '{0, 0, 0, 0};
    load_frame(-1, 1'b0);
    collect(-1, 0);
    for (int i = 0; i < 4; i++) begin
      vec_count++;
      if (got_re[i] !== er[i] || got_im[i] !== ei[i]) begin
        miscompares++;
        $display("[TB] FAIL constant_x[%0d]: got (%0d,%0d) required (%0d,%0d)", i, got_re[i], got_im[i], er[i], ei[i]);
      end
    end
  endtask

  // Single bin k=1 exercises the j=1 twiddle (0,1024)
  task automatic test_single_bin();
    int er [4] = '{256, 0, -256, 0};
    int ei [4] = '{0, 256, 0, -256};
    fr_re = '{0, 1024, 0, 0};
    fr_im = '{0, 0, 0, 0};
    load_frame(-1, 1'b0);
    collect(-1, 0);
    for (int i = 0; i < 4; i++) begin
      vec_count++;
      if (got_re[i] !== er[i] || got_im[i] !== ei[i]) begin
        miscompares++;
        $display("[TB] FAIL single_bin_x[%0d]: got (%0d,%0d) required (%0d,%0d)", i, got_re[i], got_im[i], er[i], ei[i]);
      end
    end
  endtask

  // Arithmetic shift rounds toward -inf, so -1 stays -1 through every stage
  task automatic test_floor();
    fr_re = '{-1, 0, 0, 0};
    fr_im = '{0, 0, 0, 0};
    load_frame(-1, 1'b0);
    collect(-1, 0);
    for (int i = 0; i < 4; i++) begin
      vec_count++;
      if (got_re[i] !== -1 || got_im[i] !== 0) begin
        miscompares++;
        $display("[TB] FAIL floor_x[%0d]: got (%0d,%0d) required (-1,0)", i, got_re[i], got_im[i]);
      end
    end
  endtask

  // out_ready low for 3 cycles while sample 2 is presented
  task automatic test_backpressure();
    int er [4] = '{256, 0, -256, 0};
    int ei [4] = '{0, 256, 0, -256};
    fr_re = '{0, 1024, 0, 0};
    fr_im = '{0, 0, 0, 0};
    load_frame(-1, 1'b0);
    collect(2, 3);
    for (int c = 0; c < 3; c++) begin
      vec_count++;
      if (hold_valid[c] !== 1'b1 || hold_re[c] !== -256 || hold_im[c] !== 0 || hold_last[c] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL bp_hold[%0d]: got valid=%0b (%0d,%0d) last=%0b required valid=1 (-256,0) last=0",
                 c, hold_valid[c], hold_re[c], hold_im[c], hold_last[c]);
      end
    end
    vec_count++;
    if (n_got !== 4 || post_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL bp_count: got %0d samples, trailing valid=%0b required 4 and 0", n_got, post_valid);
    end
    for (int i = 0; i < 4; i++) begin
      vec_count++;
      if (got_re[i] !== er[i] || got_im[i] !== ei[i] || got_last[i] !== (i == 3)) begin
        miscompares++;
        $display("[TB] FAIL bp_x[%0d]: got (%0d,%0d) last=%0b required (%0d,%0d) last=%0b",
                 i, got_re[i], got_im[i], got_last[i], er[i], ei[i], (i == 3));
      end
    end
  endtask

  // Second frame starts loading in the very cycle in_ready returns
  task automatic test_back_to_back();
    fr_re = '{1024, 1024, 1024, 1024};
    fr_im = '{0, 0, 0, 0};
    load_frame(-1, 1'b0);
    collect(-1, 0);
    vec_count++;
    if (got_re[0] !== 1024 || got_re[1] !== 0 || got_re[2] !== 0 || got_re[3] !== 0) begin
      miscompares++;
      $display("[TB] FAIL b2b_first: got %0d %0d %0d %0d required 1024 0 0 0", got_re[0], got_re[1], got_re[2], got_re[3]);
    end
    fr_re = '{-1, 0, 0, 0};
    load_frame(-1, 1'b1);
    collect(-1, 0);
    vec_count++;
    if (lat !== 5) begin
      miscompares++;
      $display("[TB] FAIL b2b_latency: got %0d cycles required 5", lat);
    end
    for (int i = 0; i < 4; i++) begin
      vec_count++;
      if (got_re[i] !== -1 || got_im[i] !== 0) begin
        miscompares++;
        $display("[TB] FAIL b2b_second_x[%0d]: got (%0d,%0d) required (-1,0)", i, got_re[i], got_im[i]);
      end
    end
  endtask

  // Asynchronous reset mid-COMPUTE, then a fresh impulse frame
  task automatic test_reset_compute();
    fr_re = '{0, 1024, 0, 0};
    fr_im = '{0, 0, 0, 0};
    load_frame(-1, 1'b0);
    @(posedge clk);
    #1;
    vec_count++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rc_busy_before: got %0b required 1", busy);
    end
    #1 rst = 1'b1;
    #1;
    vec_count++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rc_async: valid=%0b busy=%0b in_ready=%0b required 0 0 1", out_valid, busy, in_ready);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    fr_re = '{1024, 0, 0, 0};
    load_frame(-1, 1'b0);
    collect(-1, 0);
    vec_count++;
    if (lat !== 5 || n_got !== 4) begin
      miscompares++;
      $display("[TB] FAIL rc_frame: latency %0d samples %0d required 5 and 4", lat, n_got);
    end
    for (int i = 0; i < 4; i++) begin
      vec_count++;
      if (got_re[i] !== 256 || got_im[i] !== 0) begin
        miscompares++;
        $display("[TB] FAIL rc_x[%0d]: got (%0d,%0d) required (256,0)", i, got_re[i], got_im[i]);
      end
    end
  endtask

  // Scenario sequence and summary
  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_re     = '0;
    in_im     = '0;
    out_ready = 1'b1;
    test_reset();
    test_impulse();
    test_constant();
    test_single_bin();
    test_floor();
    test_backpressure();
    test_back_to_back();
    test_reset_compute();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
